vx_perf_memsys_csr: RTL and testbench
=====================================

# vx_perf_memsys_csr

Consumer end of the memory-system performance counter bundle. Takes the 15 counters driven by the memory system through the `VX_perf_memsys_if` slave modport and serves them as 32-bit CSR reads over a valid/ready request/response channel. A lo/hi shadow register makes 64-bit reads consistent. It sits between the core CSR unit and the memory-system perf aggregation logic.

## Interface
- `PERF_CTR_BITS`, 44: width of each counter; legal range 1..64.
- `TAG_BITS`, 8: request tag width, returned unchanged with the response.
- `BASE_LO`, 12'hB03: CSR address of counter 0, low word.
- `BASE_HI`, 12'hB83: CSR address of counter 0, high word.
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `perf_memsys_if`  in (slave modport)  15 x PERF_CTR_BITS  live counters. Index order: icache_reads=0, icache_read_misses=1, dcache_reads=2, dcache_writes=3, dcache_read_misses=4, dcache_write_misses=5, dcache_bank_stalls=6, dcache_mshr_stalls=7, smem_reads=8, smem_writes=9, smem_bank_stalls=10, mem_reads=11, mem_writes=12, mem_latency=13, mem_dup=14.
- `req_valid`  in  1  read request valid.
- `req_ready`  out  1  request accepted when high together with req_valid.
- `req_addr`  in  12  CSR address.
- `req_tag`  in  TAG_BITS  request tag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when high together with rsp_valid.
- `rsp_data`  out  32  read data.
- `rsp_tag`  out  TAG_BITS  tag of the request being answered.
- `rsp_err`  out  1  address was unmapped; rsp_data is 0.

## Operation
- Decode:
  - `req_addr - BASE_LO` in 0..14 is a lo read of that index.
  - `req_addr - BASE_HI` in 0..14 is a hi read of that index.
  - Any other address sets rsp_err=1.
- Counter value: zero-extend it to 64 bits. lo returns bits [31:0]. hi returns bits [63:32], which is 0 when PERF_CTR_BITS <= 32.
- Shadow state: shadow_data (64), shadow_idx (4), shadow_vld.
  - Accepted lo read of index i: shadow_data <= counter[i], shadow_idx <= i, shadow_vld <= 1. This overwrites any earlier shadow.
  - Accepted hi read of index i with shadow_vld && shadow_idx==i: return shadow_data[63:32], then clear shadow_vld.
  - Any other hi read returns the live counter's high word and leaves the shadow unchanged.
  - Error requests never modify the shadow.
- Response register FSM:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with rsp_ready (response replaced).
  - FULL -> EMPTY on rsp_ready with no accept.
- `req_ready = !reset && (!rsp_valid || rsp_ready)`.
- While FULL and rsp_ready=0, rsp_data, rsp_tag and rsp_err stay stable.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, shadow_vld=0, shadow_data=0, shadow_idx=0. req_ready=0 while reset is high.
- Latency: a request accepted at edge N has its response visible after edge N (rsp_valid=1 in cycle N+1).
- Counters are sampled at the accept edge; later counter changes do not alter a pending response.
- Throughput: one request per cycle while rsp_ready is held high.
- Simultaneous hi read hitting the shadow and a lo read: impossible, since there is one request per cycle.
- Reset asserted mid-response: the pending response is dropped immediately and the shadow is invalidated.
- A hi read first, then lo, then hi of the same index: the first hi returns the live value; the second hi returns the shadow.

## Test plan
- Reset: hold reset for 3 cycles with req_valid=1 -> req_ready=0 and rsp_valid=0 throughout; after release, req_ready=1.
- Lo/hi consistency: mem_latency=44'h1_FFFF_FFFF. Read B10 (lo) -> 32'hFFFF_FFFF. Counter then changes to 44'h2_0000_0005. Read B90 -> 32'h1 (shadow). Read B90 again -> 32'h2 (live).
- Shadow overwrite: lo of index 0, then lo of index 1, then hi of index 0 -> live high word of index 0, and shadow_vld stays 1 for index 1.
- Unmapped addresses: B12, B92 and 000 -> rsp_err=1, rsp_data=0, tag echoed. A following hi read still hits an existing shadow.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> exactly one request accepted, response stable. Release -> next request accepted in the same cycle as the handshake.
- Streaming: 15 lo reads with tags 0..14 back-to-back, rsp_ready=1 -> 15 responses on consecutive cycles, in order, each equal to its counter's value at accept.

Source files
------------

// File: rtl/vx_perf_memsys_csr_if.sv
// rtl/vx_perf_memsys_csr_if.sv - memory-system performance counter bundle
interface VX_perf_memsys_if #(
  parameter int PERF_CTR_BITS = 44
);
  logic [PERF_CTR_BITS-1:0] icache_reads;
  logic [PERF_CTR_BITS-1:0] icache_read_misses;
  logic [PERF_CTR_BITS-1:0] dcache_reads;
  logic [PERF_CTR_BITS-1:0] dcache_writes;
  logic [PERF_CTR_BITS-1:0] dcache_read_misses;
  logic [PERF_CTR_BITS-1:0] dcache_write_misses;
  logic [PERF_CTR_BITS-1:0] dcache_bank_stalls;
  logic [PERF_CTR_BITS-1:0] dcache_mshr_stalls;
  logic [PERF_CTR_BITS-1:0] smem_reads;
  logic [PERF_CTR_BITS-1:0] smem_writes;
  logic [PERF_CTR_BITS-1:0] smem_bank_stalls;
  logic [PERF_CTR_BITS-1:0] mem_reads;
  logic [PERF_CTR_BITS-1:0] mem_writes;
  logic [PERF_CTR_BITS-1:0] mem_latency;
  logic [PERF_CTR_BITS-1:0] mem_dup;

  modport master (
    output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
           dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
           mem_reads, mem_writes, mem_latency, mem_dup
  );

  modport slave (
    input icache_reads, icache_read_misses, dcache_reads, dcache_writes,
          dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
          dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
          mem_reads, mem_writes, mem_latency, mem_dup
  );
endinterface

// File: rtl/vx_perf_memsys_csr.sv
// rtl/vx_perf_memsys_csr.sv - CSR read port for memory-system perf counters
// with a lo/hi shadow so that 64-bit values read as a consistent pair.
module vx_perf_memsys_csr #(
  parameter int          PERF_CTR_BITS = 44,
  parameter int          TAG_BITS      = 8,
  parameter logic [11:0] BASE_LO       = 12'hB03,
  parameter logic [11:0] BASE_HI       = 12'hB83
) (
  input  logic                clk,
  input  logic                reset,
  VX_perf_memsys_if.slave     perf_memsys_if,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [11:0]         req_addr,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic                rsp_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                   state;
  logic [PERF_CTR_BITS-1:0] live [15];
  logic [63:0]              ctr  [16];
  logic [63:0]              shadow_data;
  logic [3:0]               shadow_idx;
  logic                     shadow_vld;
  logic [11:0]              off_lo;
  logic [11:0]              off_hi;
  logic                     is_lo;
  logic                     is_hi;
  logic                     accept;

  assign live[0]  = perf_memsys_if.icache_reads;
  assign live[1]  = perf_memsys_if.icache_read_misses;
  assign live[2]  = perf_memsys_if.dcache_reads;
  assign live[3]  = perf_memsys_if.dcache_writes;
  assign live[4]  = perf_memsys_if.dcache_read_misses;
  assign live[5]  = perf_memsys_if.dcache_write_misses;
  assign live[6]  = perf_memsys_if.dcache_bank_stalls;
  assign live[7]  = perf_memsys_if.dcache_mshr_stalls;
  assign live[8]  = perf_memsys_if.smem_reads;
  assign live[9]  = perf_memsys_if.smem_writes;
  assign live[10] = perf_memsys_if.smem_bank_stalls;
  assign live[11] = perf_memsys_if.mem_reads;
  assign live[12] = perf_memsys_if.mem_writes;
  assign live[13] = perf_memsys_if.mem_latency;
  assign live[14] = perf_memsys_if.mem_dup;

  // Zero-extend to 64 bits; slot 15 pads the table so a 4-bit index is always in range.
  for (genvar i = 0; i < 15; i++) begin : g_ext
    assign ctr[i] = 64'(live[i]);
  end
  assign ctr[15] = '0;

  assign off_lo    = req_addr - BASE_LO;
  assign off_hi    = req_addr - BASE_HI;
  assign is_lo     = off_lo < 12'd15;
  assign is_hi     = off_hi < 12'd15;
  assign rsp_valid = (state == FULL);
  assign req_ready = !reset && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_err     <= 1'b0;
      shadow_data <= '0;
      shadow_idx  <= '0;
      shadow_vld  <= 1'b0;
    end else if (accept) begin
      state   <= FULL;
      rsp_tag <= req_tag;
      if (is_lo) begin
        rsp_data    <= ctr[off_lo[3:0]][31:0];
        rsp_err     <= 1'b0;
        shadow_data <= ctr[off_lo[3:0]];
        shadow_idx  <= off_lo[3:0];
        shadow_vld  <= 1'b1;
      end else if (is_hi) begin
        rsp_err <= 1'b0;
        // The shadow is consumed by the matching hi read only.
        if (shadow_vld && shadow_idx == off_hi[3:0]) begin
          rsp_data   <= shadow_data[63:32];
          shadow_vld <= 1'b0;
        end else begin
          rsp_data <= ctr[off_hi[3:0]][63:32];
        end
      end else begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_vx_perf_memsys_csr.sv
// tb/tb_vx_perf_memsys_csr.sv - self-checking bench for vx_perf_memsys_csr
module tb_vx_perf_memsys_csr;
  localparam int W = 44;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_tag = '0;
  wire         req_ready;
  wire         rsp_valid;
  wire  [31:0] rsp_data;
  wire  [7:0]  rsp_tag;
  wire         rsp_err;

  logic [W-1:0] ctr [15];

  always #5 clk = ~clk;

  VX_perf_memsys_if #(.PERF_CTR_BITS(W)) pif ();
  assign pif.icache_reads        = ctr[0];
  assign pif.icache_read_misses  = ctr[1];
  assign pif.dcache_reads        = ctr[2];
  assign pif.dcache_writes       = ctr[3];
  assign pif.dcache_read_misses  = ctr[4];
  assign pif.dcache_write_misses = ctr[5];
  assign pif.dcache_bank_stalls  = ctr[6];
  assign pif.dcache_mshr_stalls  = ctr[7];
  assign pif.smem_reads          = ctr[8];
  assign pif.smem_writes         = ctr[9];
  assign pif.smem_bank_stalls    = ctr[10];
  assign pif.mem_reads           = ctr[11];
  assign pif.mem_writes          = ctr[12];
  assign pif.mem_latency         = ctr[13];
  assign pif.mem_dup             = ctr[14];

  vx_perf_memsys_csr #(
    .PERF_CTR_BITS(W), .TAG_BITS(8), .BASE_LO(12'hB03), .BASE_HI(12'hB83)
  ) dut (
    .clk(clk), .reset(rst), .perf_memsys_if(pif),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Reference model: the response slot and the lo/hi snapshot.
  bit          m_full;
  logic [31:0] m_data;
  logic [7:0]  m_tag;
  bit          m_err;
  bit          sh_v;
  int          sh_i;
  logic [63:0] sh_val;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  bit          acc;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  function automatic logic [63:0] val64(input int i);
    return 64'(ctr[i]);
  endfunction

  task automatic model_accept(input int a, input logic [7:0] tag);
    logic [63:0] v;
    m_full = 1;
    m_tag  = tag;
    m_err  = 0;
    if (a >= 'hB03 && a < 'hB03 + 15) begin
      v      = val64(a - 'hB03);
      m_data = v[31:0];
      sh_v   = 1;
      sh_i   = a - 'hB03;
      sh_val = v;
    end else if (a >= 'hB83 && a < 'hB83 + 15) begin
      if (sh_v && sh_i == a - 'hB83) begin
        v    = sh_val;
        sh_v = 0;
      end else begin
        v = val64(a - 'hB83);
      end
      m_data = v[63:32];
    end else begin
      m_err  = 1;
      m_data = 0;
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_data = 0; m_tag = 0; m_err = 0;
    sh_v = 0; sh_i = 0; sh_val = 0;
  endtask

  // One clock: check ready before the edge, advance the model, check the response after it.
  task automatic cyc();
    @(negedge clk);
    check("req_ready", req_ready, (!m_full || rsp_ready));
    acc = req_valid && req_ready;
    if (acc) begin
      n_acc++;
      model_accept(int'(req_addr), req_tag);
    end else if (rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", rsp_valid, m_full);
    if (m_full) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_tag", rsp_tag, m_tag);
      check("rsp_err", rsp_err, m_err);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [7:0] tag);
    req_valid = 1; req_addr = addr; req_tag = tag; rsp_ready = 1;
    cyc();
    req_valid = 0;
  endtask

  task automatic idle();
    req_valid = 0; rsp_ready = 1;
    cyc();
  endtask

  task automatic rand_ctrs();
    for (int i = 0; i < 15; i++) ctr[i] = W'({$urandom, $urandom});
  endtask

  initial begin
    rand_ctrs();
    model_reset();

    // Reset held with a pending request
    rst = 1; req_valid = 1; req_addr = 12'hB03; rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
    end
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    req_valid = 0;
    rst = 0;
    #1;
    check("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;

    // Lo/hi consistency across a carry
    ctr[13] = 44'h1_FFFF_FFFF;
    rd(12'hB10, 8'h01);
    check("cons_lo", rsp_data, 32'hFFFF_FFFF);
    ctr[13] = 44'h2_0000_0005;
    rd(12'hB90, 8'h02);
    check("cons_hi_shadow", rsp_data, 32'h1);
    rd(12'hB90, 8'h03);
    check("cons_hi_live", rsp_data, 32'h2);

    // Hi before lo reads live, hi after lo reads the snapshot
    ctr[2] = 44'hABC_1234_5678;
    rd(12'hB85, 8'h04);
    check("hlh_hi_live", rsp_data, 32'hABC);
    rd(12'hB05, 8'h05);
    check("hlh_lo", rsp_data, 32'h1234_5678);
    ctr[2] = 44'h111_0000_0000;
    rd(12'hB85, 8'h06);
    check("hlh_hi_shadow", rsp_data, 32'hABC);

    // Shadow overwrite
    ctr[0] = 44'h00A_0000_0001;
    ctr[1] = 44'h00B_0000_0002;
    rd(12'hB03, 8'h07);
    rd(12'hB04, 8'h08);
    check("ovw_lo1", rsp_data, 32'h2);
    ctr[0] = 44'h00C_0000_0001;
    ctr[1] = 44'h00D_0000_0002;
    rd(12'hB83, 8'h09);
    check("ovw_hi0_live", rsp_data, 32'hC);
    rd(12'hB84, 8'h0A);
    check("ovw_hi1_shadow", rsp_data, 32'hB);

    // Unmapped addresses leave the shadow alone
    ctr[4] = 44'h055_0000_0000;
    rd(12'hB07, 8'h20);
    rd(12'hB12, 8'h21);
    check("unm_b12_err", rsp_err, 1);
    check("unm_b12_data", rsp_data, 0);
    check("unm_b12_tag", rsp_tag, 8'h21);
    rd(12'hB92, 8'h22);
    check("unm_b92_err", rsp_err, 1);
    rd(12'h000, 8'h23);
    check("unm_000_err", rsp_err, 1);
    check("unm_000_tag", rsp_tag, 8'h23);
    ctr[4] = 44'h066_0000_0000;
    rd(12'hB87, 8'h24);
    check("unm_hi_shadow", rsp_data, 32'h55);
    check("unm_hi_err", rsp_err, 0);
    idle();

    // Backpressure: one accept, then a stable response
    n_acc = 0;
    rsp_ready = 0; req_valid = 1; req_addr = 12'hB06; req_tag = 8'h30;
    ctr[3] = 44'h123_4567_89AB;
    for (int k = 0; k < 5; k++) begin
      cyc();
      ctr[3] = W'({$urandom, $urandom});
      req_addr = 12'hB06 + 12'(k % 2);
    end
    check("bp_accepts", n_acc, 1);
    check("bp_data", rsp_data, 32'h4567_89AB);
    check("bp_tag", rsp_tag, 8'h30);
    rsp_ready = 1; req_addr = 12'hB08; req_tag = 8'h31;
    cyc();
    check("bp_release_accepts", n_acc, 2);
    check("bp_release_tag", rsp_tag, 8'h31);
    req_valid = 0;
    idle();

    // Streaming lo reads, counters moving every cycle
    rsp_ready = 1;
    for (int i = 0; i < 15; i++) begin
      req_valid = 1; req_addr = 12'hB03 + 12'(i); req_tag = 8'(i);
      cyc();
      check("stream_valid", rsp_valid, 1);
      check("stream_tag", rsp_tag, i);
      rand_ctrs();
    end
    req_valid = 0;
    idle();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom % 8);
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      req_tag   = 8'($urandom);
      if (r < 3)      req_addr = 12'hB03 + 12'($urandom % 15);
      else if (r < 6) req_addr = 12'hB83 + 12'($urandom % 15);
      else if (r == 6) begin
        case ($urandom % 4)
          0: req_addr = 12'hB12;
          1: req_addr = 12'hB92;
          2: req_addr = 12'hB02;
          default: req_addr = 12'hB82;
        endcase
      end else req_addr = 12'($urandom);
      if (($urandom % 4) == 0) ctr[$urandom % 15] = W'({$urandom, $urandom});
      cyc();
    end
    req_valid = 0;
    idle();

    // Reset arriving mid-response drops it and invalidates the shadow
    ctr[2] = 44'h321_0000_0000;
    rd(12'hB05, 8'h40);
    rsp_ready = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    ctr[2] = 44'h654_0000_0000;
    rd(12'hB85, 8'h41);
    check("mid_rst_hi_live", rsp_data, 32'h654);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
